disp_scan: RTL

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_scan.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/disp_scan.sv
// Six-digit multiplexed seven-segment scanner with per-frame input snapshot,
// edit-field blinking, colon blink and alarm LED.
module disp_scan #(
  parameter int DWELL      = 1,
  parameter int BLINK_HALF = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [3:0] sec,
  input  logic [3:0] thi,
  input  logic [3:0] four,
  input  logic [3:0] five,
  input  logic [3:0] six,
  input  logic       set_clr,
  input  logic       set_alarm,
  input  logic       set_hour,
  input  logic       set_min,
  input  logic       set_sec,
  input  logic       alarm_flag,
  output logic [5:0] an,
  output logic [7:0] seg_out,
  output logic       led_alarm
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_HALF - 1);

  logic [7:0]  dwell_cnt_r;
  logic [2:0]  idx_r;
  logic [9:0]  blink_cnt_r;
  logic        blink_r;
  logic [6:0]  snap_seg_r;
  logic [19:0] snap_bcd_r;
  logic [5:0]  an_r;
  logic [7:0]  seg_r;
  logic        led_r;

  logic        advance_s;
  logic [2:0]  idx_nxt_s;
  logic        frame_start_s;
  logic [6:0]  view_seg_s;
  logic [19:0] view_bcd_s;
  logic [6:0]  raw_seg_s;
  logic [5:0]  an_nxt_s;
  logic        set_mode_s;
  logic [1:0]  field_s;
  logic        blank_s;
  logic        dp_s;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // Scan sequencing; the first cycle of digit 0 also captures the frame, so it
  // displays the live inputs being latched into the snapshot.
  always_comb begin
    advance_s     = (dwell_cnt_r == DWELL_LAST);
    idx_nxt_s     = (idx_r >= 3'd5) ? 3'd0 : idx_r + 3'd1;
    frame_start_s = (idx_r == 3'd0) && (dwell_cnt_r == 8'd0);
    if (frame_start_s) begin
      view_seg_s = seg_in;
      view_bcd_s = {six, five, four, thi, sec};
    end else begin
      view_seg_s = snap_seg_r;
      view_bcd_s = snap_bcd_r;
    end
  end

  // Digit mux and anode pattern for the current index.
  always_comb begin
    case (idx_r)
      3'd0:    begin raw_seg_s = view_seg_s;                    an_nxt_s = 6'b111110; end
      3'd1:    begin raw_seg_s = bcd_to_seg(view_bcd_s[3:0]);   an_nxt_s = 6'b111101; end
      3'd2:    begin raw_seg_s = bcd_to_seg(view_bcd_s[7:4]);   an_nxt_s = 6'b111011; end
      3'd3:    begin raw_seg_s = bcd_to_seg(view_bcd_s[11:8]);  an_nxt_s = 6'b110111; end
      3'd4:    begin raw_seg_s = bcd_to_seg(view_bcd_s[15:12]); an_nxt_s = 6'b101111; end
      3'd5:    begin raw_seg_s = bcd_to_seg(view_bcd_s[19:16]); an_nxt_s = 6'b011111; end
      default: begin raw_seg_s = 7'b0000000;                    an_nxt_s = 6'b111111; end
    endcase
  end

  // Edit field selection (1=sec, 2=min, 3=hour); alarm set has no seconds field.
  always_comb begin
    set_mode_s = set_clr | set_alarm;
    if (set_sec && !set_alarm) begin
      field_s = 2'd1;
    end else if (set_min) begin
      field_s = 2'd2;
    end else if (set_hour) begin
      field_s = 2'd3;
    end else begin
      field_s = 2'd0;
    end
    blank_s = set_mode_s && blink_r && (field_s != 2'd0) &&
              ((idx_r[2:1] + 2'd1) == field_s);
    dp_s    = ((idx_r == 3'd2) || (idx_r == 3'd4)) && (set_mode_s || !blink_r);
  end

  // Dwell counter, digit index and frame snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_cnt_r <= 8'd0;
      idx_r       <= 3'd0;
      snap_seg_r  <= 7'd0;
      snap_bcd_r  <= 20'd0;
    end else begin
      if (advance_s) begin
        dwell_cnt_r <= 8'd0;
        idx_r       <= idx_nxt_s;
      end else begin
        dwell_cnt_r <= dwell_cnt_r + 8'd1;
      end
      if (frame_start_s) begin
        snap_seg_r <= seg_in;
        snap_bcd_r <= {six, five, four, thi, sec};
      end
    end
  end

  // Free-running blink phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_r <= 10'd0;
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= 10'd0;
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 10'd1;
    end
  end

  // Registered display and LED outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= 6'b111111;
      seg_r <= 8'h00;
      led_r <= 1'b0;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= {dp_s, (blank_s ? 7'b0000000 : raw_seg_s)};
      led_r <= alarm_flag & blink_r;
    end
  end

  assign an        = an_r;
  assign seg_out   = seg_r;
  assign led_alarm = led_r;

endmodule
